// File: rtl/regwrite_arbiter_pkg.sv
// Shared definitions for the two-requester register-file write arbiter.
// Holds the default address/data widths, the packed write-request payload
// (also used by the register-file wrapper) and the arbitration helper.
// Optional feature macro: REGWRITE_ARB_RR_EN (round-robin contention pointer).
package regwrite_arbiter_pkg;

   localparam int unsigned REGWRITE_AW = 2;
   localparam int unsigned REGWRITE_DW = 8;

   // One register-file write: prep-select, destination index, data.
   typedef struct packed {
      logic                   prep;
      logic [REGWRITE_AW-1:0] reg_idx;
      logic [REGWRITE_DW-1:0] data;
   } wr_req_t;

   // Requester whose buffer owns the write port; 0 when nothing is held.
   function automatic logic pick_winner(input logic full0, input logic full1,
                                        input logic prio);
      return (full0 && full1) ? prio : (full1 && !full0);
   endfunction

endpackage

// File: rtl/regwrite_holdbuf.sv
// One-entry hold buffer for a single write requester.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_i             requester offers a write
//   prep_i/reg_i/data_i offered write payload
//   grant_i             arbiter drains this buffer at the coming edge
//   ready_o             buffer can take the offered write this cycle
//   full_o              buffer holds a write
//   prep_o/reg_o/data_o held write payload
module regwrite_holdbuf
   import regwrite_arbiter_pkg::*;
#(
   parameter int unsigned AW = REGWRITE_AW,
   parameter int unsigned DW = REGWRITE_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_i,
   input  logic          prep_i,
   input  logic [AW-1:0] reg_i,
   input  logic [DW-1:0] data_i,
   input  logic          grant_i,
   output logic          ready_o,
   output logic          full_o,
   output logic          prep_o,
   output logic [AW-1:0] reg_o,
   output logic [DW-1:0] data_o
);

   logic          full_q;
   logic          full_d;
   logic          load;
   logic          prep_q;
   logic [AW-1:0] reg_q;
   logic [DW-1:0] data_q;

   // A granted buffer empties at this edge, so it can refill in the same cycle.
   assign ready_o = !full_q || grant_i;
   assign load    = valid_i && ready_o && !reset;

   // Occupancy next-state: a reload wins over the drain.
   always_comb begin
      full_d = full_q;
      if (grant_i) full_d = 1'b0;
      if (load)    full_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) full_q <= 1'b0;
      else       full_q <= full_d;
   end

   // Payload only changes on a load; the register index is meaningless for prep.
   always_ff @(posedge clk) begin
      if (load) begin
         prep_q <= prep_i;
         reg_q  <= prep_i ? '0 : reg_i;
         data_q <= data_i;
      end
   end

   assign full_o = full_q;
   assign prep_o = prep_q;
   assign reg_o  = reg_q;
   assign data_o = data_q;

endmodule

// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter. Each requester owns a one-entry
// hold buffer; at most one full buffer drives the write port per cycle.
// Contention: requester 0 always wins, or with REGWRITE_ARB_RR_EN defined a
// priority pointer flips to the other requester after every contended grant.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   reqN_valid/ready               per-requester handshake (ready is combinational)
//   reqN_prep/reg/data             per-requester write payload
//   WriteEnabled/WritePrepReg      register-file write strobe / prep select
//   WriteReg/WriteData             register-file write index / data
//   pending                        bit r set while a held write targets register r
//   prep_pending                   set while a held write targets prep
//   grant_id                       requester driving the port (valid with WriteEnabled)
module regwrite_arbiter
   import regwrite_arbiter_pkg::*;
#(
   parameter int unsigned AW = REGWRITE_AW,
   parameter int unsigned DW = REGWRITE_DW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic                     req0_prep,
   input  logic [AW-1:0]            req0_reg,
   input  logic [DW-1:0]            req0_data,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic                     req1_prep,
   input  logic [AW-1:0]            req1_reg,
   input  logic [DW-1:0]            req1_data,
   output logic                     WriteEnabled,
   output logic                     WritePrepReg,
   output logic [AW-1:0]            WriteReg,
   output logic [DW-1:0]            WriteData,
   output logic [(32'd1<<AW)-1:0]   pending,
   output logic                     prep_pending,
   output logic                     grant_id
);

   localparam int unsigned NREG = 32'd1 << AW;

   logic          full0, full1;
   logic          prep0, prep1;
   logic [AW-1:0] reg0,  reg1;
   logic [DW-1:0] data0, data1;
   logic          grant0, grant1;
   logic          gnt_id;
   logic          prio;

   regwrite_holdbuf #(.AW(AW), .DW(DW)) u_buf0 (
      .clk     (clk),
      .reset   (reset),
      .valid_i (req0_valid),
      .prep_i  (req0_prep),
      .reg_i   (req0_reg),
      .data_i  (req0_data),
      .grant_i (grant0),
      .ready_o (req0_ready),
      .full_o  (full0),
      .prep_o  (prep0),
      .reg_o   (reg0),
      .data_o  (data0)
   );

   regwrite_holdbuf #(.AW(AW), .DW(DW)) u_buf1 (
      .clk     (clk),
      .reset   (reset),
      .valid_i (req1_valid),
      .prep_i  (req1_prep),
      .reg_i   (req1_reg),
      .data_i  (req1_data),
      .grant_i (grant1),
      .ready_o (req1_ready),
      .full_o  (full1),
      .prep_o  (prep1),
      .reg_o   (reg1),
      .data_o  (data1)
   );

`ifdef REGWRITE_ARB_RR_EN
   logic ptr_q;
   logic ptr_d;

   // Pointer flips away from the winner only when both buffers competed.
   always_comb begin
      ptr_d = ptr_q;
      if (full0 && full1) ptr_d = ~gnt_id;
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= 1'b0;
      else       ptr_q <= ptr_d;
   end

   assign prio = ptr_q;
`else
   assign prio = 1'b0;
`endif

   // Grant selection.
   always_comb begin
      gnt_id = pick_winner(full0, full1, prio);
      grant0 = full0 && !gnt_id;
      grant1 = full1 &&  gnt_id;
   end

   // Write port driven straight from the granted buffer; all zero when idle.
   always_comb begin
      WriteEnabled = 1'b0;
      WritePrepReg = 1'b0;
      WriteReg     = '0;
      WriteData    = '0;
      grant_id     = 1'b0;
      if (full0 || full1) begin
         WriteEnabled = 1'b1;
         grant_id     = gnt_id;
         WritePrepReg = gnt_id ? prep1 : prep0;
         WriteReg     = gnt_id ? reg1  : reg0;
         WriteData    = gnt_id ? data1 : data0;
      end
   end

   // Hazard flags cover every held write, including the one being granted.
   always_comb begin
      pending      = '0;
      prep_pending = (full0 && prep0) || (full1 && prep1);
      if (full0 && !prep0) pending = pending | (NREG'(1) << reg0);
      if (full1 && !prep1) pending = pending | (NREG'(1) << reg1);
   end

endmodule

// File: tb/tb_regwrite_arbiter.sv
module tb_regwrite_arbiter;
   import regwrite_arbiter_pkg::*;

   localparam int unsigned AW = REGWRITE_AW;
   localparam int unsigned DW = REGWRITE_DW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0, req0_prep = 1'b0;
   logic [AW-1:0] req0_reg = '0;
   logic [DW-1:0] req0_data = '0;
   logic          req1_valid = 1'b0, req1_prep = 1'b0;
   logic [AW-1:0] req1_reg = '0;
   logic [DW-1:0] req1_data = '0;
   logic          req0_ready, req1_ready;
   logic          WriteEnabled, WritePrepReg, grant_id, prep_pending;
   logic [AW-1:0] WriteReg;
   logic [DW-1:0] WriteData;
   logic [3:0]    pending;

   int checks = 0;
   int errors = 0;

   wr_req_t       q0[$];
   wr_req_t       q1[$];
   logic [DW-1:0] reg_model [4];

   regwrite_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_prep    (req0_prep),
      .req0_reg     (req0_reg),
      .req0_data    (req0_data),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_prep    (req1_prep),
      .req1_reg     (req1_reg),
      .req1_data    (req1_data),
      .WriteEnabled (WriteEnabled),
      .WritePrepReg (WritePrepReg),
      .WriteReg     (WriteReg),
      .WriteData    (WriteData),
      .pending      (pending),
      .prep_pending (prep_pending),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          v0, p0;
      logic [AW-1:0] r0;
      logic [DW-1:0] d0;
      logic          v1, p1;
      logic [AW-1:0] r1;
      logic [DW-1:0] d1;
      logic          chk;
      logic [19:0]   exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t vi(input logic rst, input logic v0, input logic p0,
                               input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                               input logic v1, input logic p1,
                               input logic [AW-1:0] r1, input logic [DW-1:0] d1);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.p0 = p0; v.r0 = r0; v.d0 = d0;
      v.v1 = v1; v.p1 = p1; v.r1 = r1; v.d1 = d1;
      v.chk = 1'b0; v.exp = '0;
      return v;
   endfunction

   // Expected {ready0, ready1, WE, prep, reg, data, grant_id, pending, prep_pending}.
   function automatic logic [19:0] eo(input logic rd0, input logic rd1, input logic we,
                                      input logic wp, input logic [1:0] wr,
                                      input logic [7:0] wd, input logic g,
                                      input logic [3:0] pn, input logic pp);
      return {rd0, rd1, we, wp, wr, wd, g, pn, pp};
   endfunction

   function automatic vec_t ve(input vec_t b, input logic [19:0] e);
      vec_t v;
      v = b; v.chk = 1'b1; v.exp = e;
      return v;
   endfunction

   // One clock cycle: drive, check outputs, track writes, record accepts.
   task automatic cycle(input vec_t v, input string name, output logic acc0, output logic acc1);
      logic [19:0] act;
      wr_req_t     e;
      @(negedge clk);
      reset = v.rst;
      req0_valid = v.v0; req0_prep = v.p0; req0_reg = v.r0; req0_data = v.d0;
      req1_valid = v.v1; req1_prep = v.p1; req1_reg = v.r1; req1_data = v.d1;
      #1;
      act = {req0_ready, req1_ready, WriteEnabled, WritePrepReg, WriteReg, WriteData,
             grant_id, pending, prep_pending};
      if (v.chk) begin
         checks++;
         if (act !== v.exp) begin
            errors++;
            $display("FAIL %s: outputs got %05h expected %05h", name, act, v.exp);
         end
      end
      if (WriteEnabled === 1'b1) begin
         checks++;
         if ((grant_id ? q1.size() : q0.size()) == 0) begin
            errors++;
            $display("FAIL %s: unexpected write from req%0d data %02h", name, grant_id, WriteData);
         end else begin
            e = grant_id ? q1.pop_front() : q0.pop_front();
            if (e.prep !== WritePrepReg || e.data !== WriteData ||
                (!e.prep && e.reg_idx !== WriteReg)) begin
               errors++;
               $display("FAIL %s: write req%0d got p%0d r%0d d%02h expected p%0d r%0d d%02h",
                        name, grant_id, WritePrepReg, WriteReg, WriteData,
                        e.prep, e.reg_idx, e.data);
            end
         end
         if (!WritePrepReg) reg_model[WriteReg] = WriteData;
      end
      if (reset) begin
         q0.delete();
         q1.delete();
      end
      acc0 = !reset && req0_valid && req0_ready;
      acc1 = !reset && req1_valid && req1_ready;
      if (acc0) q0.push_back('{prep: v.p0, reg_idx: v.r0, data: v.d0});
      if (acc1) q1.push_back('{prep: v.p1, reg_idx: v.r1, data: v.d1});
   endtask

   initial begin
      logic [19:0] idle;
      logic        a0, a1;
      logic        o0v, o1v;
      wr_req_t     o0, o1;

      idle = eo(1, 1, 0, 0, 2'd0, 8'h00, 0, 4'b0000, 0);

      // Reset, single write (reg2 = A5).
      tbl.push_back(ve(vi(1, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      tbl.push_back(ve(vi(0, 1,0,2'd2,8'hA5, 0,0,2'd0,8'h00), idle));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd2,8'hA5,0,4'b0100,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      // Contention round 1.
      tbl.push_back(ve(vi(0, 1,0,2'd1,8'h11, 1,0,2'd3,8'h33), idle));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,0,1,0,2'd1,8'h11,0,4'b1010,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd3,8'h33,1,4'b1000,0)));
      // Contention round 2: order depends on round-robin.
      tbl.push_back(ve(vi(0, 1,0,2'd1,8'h11, 1,0,2'd3,8'h33), idle));
`ifdef REGWRITE_ARB_RR_EN
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(0,1,1,0,2'd3,8'h33,1,4'b1010,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd1,8'h11,0,4'b0010,0)));
`else
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,0,1,0,2'd1,8'h11,0,4'b1010,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd3,8'h33,1,4'b1000,0)));
`endif
      // Contention round 3: req0 first in both builds.
      tbl.push_back(ve(vi(0, 1,0,2'd1,8'h11, 1,0,2'd3,8'h33), idle));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,0,1,0,2'd1,8'h11,0,4'b1010,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd3,8'h33,1,4'b1000,0)));
      // Reset, then both requesters target reg0.
      tbl.push_back(ve(vi(1, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      tbl.push_back(ve(vi(0, 1,0,2'd0,8'h01, 1,0,2'd0,8'h02), idle));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,0,1,0,2'd0,8'h01,0,4'b0001,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd0,8'h02,1,4'b0001,0)));
      // Prep write from req1.
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 1,1,2'd0,8'h7E), idle));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,1,2'd0,8'h7E,1,4'b0000,1)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      // Back-to-back writes from req0 (drain and reload each cycle).
      tbl.push_back(ve(vi(0, 1,0,2'd1,8'hC1, 0,0,2'd0,8'h00), idle));
      tbl.push_back(ve(vi(0, 1,0,2'd2,8'hC2, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd1,8'hC1,0,4'b0010,0)));
      tbl.push_back(ve(vi(0, 1,0,2'd3,8'hC3, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd2,8'hC2,0,4'b0100,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,1,1,0,2'd3,8'hC3,0,4'b1000,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      // Reset while req1 is held behind req0.
      tbl.push_back(ve(vi(1, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      tbl.push_back(ve(vi(0, 1,0,2'd1,8'hD0, 1,0,2'd2,8'hD1), idle));
      tbl.push_back(ve(vi(1, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), eo(1,0,1,0,2'd1,8'hD0,0,4'b0110,0)));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      // Offer during reset is not captured.
      tbl.push_back(ve(vi(1, 1,0,2'd1,8'hEE, 0,0,2'd0,8'h00), idle));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));
      tbl.push_back(ve(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), idle));

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i], $sformatf("vec%0d", i), a0, a1);
         if (i == 16) begin
            checks++;
            if (reg_model[0] !== 8'h02) begin
               errors++;
               $display("FAIL same_reg_final: reg0 got %02h expected 02", reg_model[0]);
            end
         end
      end

      // Random traffic: offers held until accepted, per-requester order checked.
      o0v = 1'b0; o1v = 1'b0; o0 = '0; o1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (!o0v && $urandom_range(0, 3) != 0) begin
            o0v = 1'b1;
            o0.prep = ($urandom_range(0, 7) == 0); o0.reg_idx = AW'($urandom); o0.data = DW'($urandom);
         end
         if (!o1v && $urandom_range(0, 3) != 0) begin
            o1v = 1'b1;
            o1.prep = ($urandom_range(0, 7) == 0); o1.reg_idx = AW'($urandom); o1.data = DW'($urandom);
         end
         cycle(vi(0, o0v, o0.prep, o0.reg_idx, o0.data, o1v, o1.prep, o1.reg_idx, o1.data),
               "rand", a0, a1);
         if (a0) o0v = 1'b0;
         if (a1) o1v = 1'b0;
      end
      for (int i = 0; i < 4; i++)
         cycle(vi(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00), "drain", a0, a1);

      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain_empty: outstanding writes req0=%0d req1=%0d expected 0",
                  q0.size(), q1.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
